keypad_scan_pulse: RTL and testbench

//  Scans a 4x4 active-low matrix keypad, debounces it, and emits one-cycle key events.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_col_scanner.sv | 107 ++++++++++
 rtl/keypad_scan_pulse.sv | 152 +++++++++++++++
 tb/tb_keypad_scan_pulse.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan/debounce block.
//   key_state_e : debounce FSM states
//   scan_kind_e : classification of one full four-column scan
//   KEY_MAP     : 16-entry table, index {row,col} -> key code
//   KEY_VALID   : valid bit placed in front of the code on key_pulse
package keypad_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_PRESS   = 2'd1,
    KS_HELD    = 2'd2,
    KS_RELEASE = 2'd3
  } key_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  localparam logic KEY_VALID = 1'b1;

  // Nibble i holds the code for index i = row*4 + col.
  // Row 0: 1 2 3 A, row 1: 4 5 6 B, row 2: 7 8 9 E, row 3: F 0 C D.
  localparam logic [63:0] KEY_MAP = 64'hDC0F_E987_B654_A321;

  function automatic logic [3:0] key_map_code(input logic [3:0] idx);
    return KEY_MAP[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scanner for a 4x4 active-low keypad matrix.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   row_n      : raw keypad rows (asynchronous, low = closed)
//   col_n      : column drive, one bit low at a time, rotating 0..3
//   scan_done  : high for one cycle on the last cycle of column 3
//   scan_kind  : NONE / SINGLE / MULTI for the scan ending this cycle
//   scan_idx   : {row,col} of the closure when scan_kind is SINGLE
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       scan_done,
  output scan_kind_e scan_kind,
  output logic [3:0] scan_idx
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [DIVW-1:0] div_cnt;
  logic [1:0]      col_sel;
  logic [1:0]      acc_cnt;
  logic [3:0]      acc_idx;

  logic       dwell_end;
  logic [3:0] closed;
  logic [2:0] hit_sum;
  logic [1:0] col_hits;
  logic [1:0] col_row;
  logic [1:0] base_cnt;
  logic [3:0] base_idx;
  logic [2:0] tot_sum;
  logic [1:0] tot_cnt;
  logic [3:0] tot_idx;
  logic [1:0] next_col;

  assign dwell_end = (div_cnt == DIV_LAST);
  assign closed    = ~row_sync;
  assign next_col  = col_sel + 2'd1;

  // Per-column closure count saturates at 2: anything beyond "more than one"
  // carries no extra meaning for the result.
  always_comb begin
    hit_sum = 3'd0;
    col_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      hit_sum = hit_sum + {2'b00, closed[r]};
      if (closed[r]) col_row = 2'(r);
    end
    col_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  end

  // Column 0 starts a fresh accumulation; later columns merge into it.
  always_comb begin
    base_cnt = (col_sel == 2'd0) ? 2'd0 : acc_cnt;
    base_idx = (col_sel == 2'd0) ? 4'd0 : acc_idx;
    tot_sum  = {1'b0, base_cnt} + {1'b0, col_hits};
    tot_cnt  = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    tot_idx  = (col_hits != 2'd0) ? {col_row, col_sel} : base_idx;
  end

  always_comb begin
    case (tot_cnt)
      2'd0:    scan_kind = SCAN_NONE;
      2'd1:    scan_kind = SCAN_SINGLE;
      default: scan_kind = SCAN_MULTI;
    endcase
  end

  // The result is presented combinationally on the final dwell cycle so the
  // debounce FSM can register its pulse on the very next edge.
  assign scan_done = dwell_end && (col_sel == 2'd3);
  assign scan_idx  = tot_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div_cnt  <= '0;
      col_sel  <= 2'd0;
      col_n    <= 4'b1110;
      acc_cnt  <= 2'd0;
      acc_idx  <= 4'd0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      if (dwell_end) begin
        div_cnt <= '0;
        col_sel <= next_col;
        col_n   <= ~(4'b0001 << next_col);
        acc_cnt <= tot_cnt;
        acc_idx <= tot_idx;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_pulse.sv
// Keypad scanner with press/release debounce and one-cycle key events.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   row_n     : keypad rows (asynchronous, low = closed on driven column)
//   col_n     : column drive, one bit low at a time
//   key_pulse : {1,code} for one cycle per accepted press, else 0
//   key_code  : code of the last accepted key
//   key_held  : high from accept until the release is debounced
//
// state   | meaning
// IDLE    | no key; waiting for a single closure
// PRESS   | same single key seen cnt consecutive scans
// HELD    | key accepted; waiting for an empty scan
// RELEASE | empty for cnt consecutive scans; any closure returns to HELD
module keypad_scan_pulse
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key_pulse,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [1:0] ST_IDLE    = KS_IDLE;
  localparam logic [1:0] ST_PRESS   = KS_PRESS;
  localparam logic [1:0] ST_HELD    = KS_HELD;
  localparam logic [1:0] ST_RELEASE = KS_RELEASE;

  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_SCANS - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
  localparam logic [DBW-1:0] DB_MAX  = '1;

  logic       scan_done;
  scan_kind_e scan_kind;
  logic [3:0] scan_idx;

  logic [1:0]     state_q, state_d;
  logic [3:0]     cand_q, cand_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic [DBW-1:0] cnt_inc;
  logic           accept;
  logic           release_done;

  keypad_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_idx  (scan_idx)
  );

  assign cnt_inc = (cnt_q == DB_MAX) ? cnt_q : cnt_q + DB_ONE;

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    release_done = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_idx;
            cnt_d  = DB_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_PRESS;
            end
          end
        end
        ST_PRESS: begin
          if (scan_kind == SCAN_SINGLE) begin
            if (scan_idx == cand_q) begin
              if (cnt_q == DB_LAST) begin
                accept  = 1'b1;
                state_d = ST_HELD;
              end
              cnt_d = cnt_inc;
            end else begin
              cand_d = scan_idx;
              cnt_d  = DB_ONE;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (scan_kind == SCAN_NONE) begin
            cnt_d = DB_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              release_done = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (scan_kind == SCAN_NONE) begin
            if (cnt_q == DB_LAST) begin
              release_done = 1'b1;
              cnt_d        = '0;
              state_d      = ST_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= '0;
      key_pulse <= 5'h00;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_pulse <= accept ? {KEY_VALID, key_map_code(cand_d)} : 5'h00;
      if (accept) begin
        key_code <= key_map_code(cand_d);
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_pulse.sv
// Directed bench for keypad_scan_pulse with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A matrix model drives row_n from col_n and a 16-bit key vector; expected
// pulses are queued when keys are pressed and consumed by a negedge monitor.
module tb_keypad_scan_pulse;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [4:0]  key_pulse;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];
  logic [4:0] prev_pulse = 5'h00;

  always #5 clk = ~clk;

  assign row_n = {~|(keys[15:12] & ~col_n), ~|(keys[11:8] & ~col_n),
                  ~|(keys[7:4] & ~col_n), ~|(keys[3:0] & ~col_n)};

  keypad_scan_pulse #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_pulse (key_pulse),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every nonzero pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_pulse != 5'h00) check("pulse_gap", 16'(key_pulse), 16'h0);
      if (key_pulse !== 5'h00) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 16'(key_pulse), 16'h0);
        else check("pulse_value", 16'(key_pulse), 16'(exp_q.pop_front()));
      end
      prev_pulse <= key_pulse;
    end else begin
      prev_pulse <= 5'h00;
    end
  end

  task automatic wait_drain(input string tag, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(exp_q.size()), 16'h0);
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  initial begin
    int n;
    logic found;

    // 1: reset state and column rotation
    repeat (20) @(negedge clk);
    check("rst_col_n", 16'(col_n), 16'hE);
    check("rst_pulse", 16'(key_pulse), 16'h0);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("col_rotate", 16'(col_n), 16'(~(4'b0001 << ((k / SD) % 4)) & 4'hF));
    end

    // 2: steady r0c0
    keys = 16'h0001;
    exp_q.push_back(5'h11);
    wait_drain("s2_pulse", 8 * SCAN);
    check("s2_held", 16'(key_held), 16'h1);
    check("s2_code", 16'(key_code), 16'h1);
    wait_scans(3);
    keys = 16'h0000;
    wait_scans(5);
    check("s2_released", 16'(key_held), 16'h0);

    // 3: r0c3, release, r3c1
    keys = 16'h0008;
    exp_q.push_back(5'h1A);
    wait_drain("s3_pulse_a", 8 * SCAN);
    check("s3_code_a", 16'(key_code), 16'hA);
    keys = 16'h0000;
    wait_scans(5);
    check("s3_released", 16'(key_held), 16'h0);
    keys = 16'h2000;
    exp_q.push_back(5'h10);
    wait_drain("s3_pulse_0", 8 * SCAN);
    check("s3_code_0", 16'(key_code), 16'h0);
    check("s3_held", 16'(key_held), 16'h1);
    keys = 16'h0000;
    wait_scans(5);

    // 4: bounce on r1c1 is rejected
    keys = 16'h0020;
    wait_scans(2);
    keys = 16'h0000;
    wait_scans(1);
    keys = 16'h0020;
    wait_scans(2);
    keys = 16'h0000;
    wait_scans(4);
    check("s4_no_held", 16'(key_held), 16'h0);
    check("s4_code_kept", 16'(key_code), 16'h0);

    // 5: two keys together, then one released
    keys = 16'h0003;
    wait_scans(5);
    check("s5_multi_no_held", 16'(key_held), 16'h0);
    keys = 16'h0001;
    exp_q.push_back(5'h11);
    wait_drain("s5_pulse", 8 * SCAN);
    check("s5_code", 16'(key_code), 16'h1);
    keys = 16'h0000;
    wait_scans(5);

    // 6: r2c2 with a one-scan release glitch, then reset during HELD
    keys = 16'h0400;
    exp_q.push_back(5'h19);
    wait_drain("s6_pulse", 8 * SCAN);
    keys = 16'h0000;
    repeat (SCAN) @(negedge clk);
    keys = 16'h0400;
    wait_scans(4);
    check("s6_glitch_held", 16'(key_held), 16'h1);
    check("s6_code", 16'(key_code), 16'h9);
    rst = 1'b0;
    #1;
    check("s6_rst_held", 16'(key_held), 16'h0);
    check("s6_rst_code", 16'(key_code), 16'h0);
    check("s6_rst_pulse", 16'(key_pulse), 16'h0);
    check("s6_rst_col", 16'(col_n), 16'hE);
    repeat (5) @(negedge clk);
    exp_q.push_back(5'h19);
    rst = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (key_pulse !== 5'h00) found = 1'b1;
    end
    check("s6_relatency", 16'(n), 16'd48);
    wait_drain("s6_repulse", 2 * SCAN);
    check("s6_reheld", 16'(key_held), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
